// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - definitions shared by the sequential ALU
// Purpose: opcode mnemonics (encodings inherited from the single-cycle ALU)
//          and the FSM state type of alu_seq.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      LSH = 4'b0000,
      RSH = 4'b0001,
      AND = 4'b0010,
      OR  = 4'b0011,
      GEQ = 4'b1000,
      EQ  = 4'b1001,
      NEG = 4'b1010,
      ADD = 4'b1011,
      NEQ = 4'b1101
   } op_mne;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result handshake bundle of alu_seq
// Purpose: groups the operation request (in_*, InputA, InputB, OP) and the
//          result (out_*, Out, flags) of the ALU.
// Modports: master = operation source / result consumer, slave = the ALU.
interface alu_seq_if #(parameter int W = 8);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] InputA;
   logic [W-1:0] InputB;
   logic [3:0]   OP;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Out;
   logic         Zero;
   logic         Carry;
   logic         Negative;
   logic         Illegal;

   modport master (
      output in_valid, InputA, InputB, OP, out_ready,
      input  in_ready, out_valid, Out, Zero, Carry, Negative, Illegal
   );

   modport slave (
      input  in_valid, InputA, InputB, OP, out_ready,
      output in_ready, out_valid, Out, Zero, Carry, Negative, Illegal
   );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational part of the sequential ALU
// Purpose: computes every non-shift result, the ADD carry and the illegal
//          opcode decode in one pass.
// Ports: a, b   - operands (W bits)
//        op     - opcode
//        res    - result (W bits); LSH/RSH return a unchanged (amount 0 case)
//        carry  - ADD carry-out, 0 otherwise
//        illegal- op is not a defined opcode
module alu_comb
   import alu_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [3:0]   op,
   output logic [W-1:0] res,
   output logic         carry,
   output logic         illegal
);

   logic [W:0] sum;

   always_comb begin
      sum     = {1'b0, a} + {1'b0, b};
      res     = '0;
      carry   = 1'b0;
      illegal = 1'b0;
      case (op_mne'(op))
         // Non-zero shift amounts are iterated by alu_seq; only the
         // zero-amount passthrough is resolved here.
         LSH, RSH: res = a;
         AND:      res = a & b;
         OR:       res = a | b;
         GEQ:      res = {{(W-1){1'b0}}, (a >= b)};
         EQ:       res = {{(W-1){1'b0}}, (a == b)};
         NEG:      res = ~a + {{(W-1){1'b0}}, 1'b1};
         ADD: begin
            res   = sum[W-1:0];
            carry = sum[W];
         end
         NEQ:      res = {{(W-1){1'b0}}, (a != b)};
         default:  illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked W-bit ALU with iterative one-bit-per-cycle shifts
// Purpose: accepts one operation when idle, produces a registered result
//          with Zero/Carry/Negative/Illegal flags and holds it until the
//          consumer takes it.
// Ports: Clk   - clock, rising edge
//        Reset - synchronous, active-high
//        bus   - alu_seq_if slave modport (request in, result out)
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int W = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   alu_seq_if.slave   bus
);

   localparam int SHW = $clog2(W) + 1;

   alu_state_t     state;
   logic [W-1:0]   acc;
   logic [SHW-1:0] cnt;
   logic           dir_right;

   logic [W-1:0]   res_c;
   logic           carry_c;
   logic           illegal_c;
   logic           is_shift;
   logic [SHW-1:0] amt;
   logic [W-1:0]   acc_nxt;

   alu_comb #(.W(W)) u_comb (
      .a       (bus.InputA),
      .b       (bus.InputB),
      .op      (bus.OP),
      .res     (res_c),
      .carry   (carry_c),
      .illegal (illegal_c)
   );

   assign is_shift = (bus.OP == LSH) || (bus.OP == RSH);
   // Amounts of W or more shift every bit out, so clamp to W.
   assign amt      = (bus.InputB >= W'(W)) ? SHW'(W) : SHW'(bus.InputB);
   assign acc_nxt  = dir_right ? (acc >> 1) : (acc << 1);

   assign bus.in_ready  = (state == IDLE) && !Reset;
   assign bus.out_valid = (state == DONE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= IDLE;
         acc          <= '0;
         cnt          <= '0;
         dir_right    <= 1'b0;
         bus.Out      <= '0;
         bus.Zero     <= 1'b0;
         bus.Carry    <= 1'b0;
         bus.Negative <= 1'b0;
         bus.Illegal  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (is_shift && (amt != '0)) begin
                     acc       <= bus.InputA;
                     cnt       <= amt;
                     dir_right <= (bus.OP == RSH);
                     state     <= SHIFT;
                  end else begin
                     bus.Out      <= res_c;
                     bus.Zero     <= (res_c == '0);
                     bus.Carry    <= carry_c;
                     bus.Negative <= res_c[W-1];
                     bus.Illegal  <= illegal_c;
                     state        <= DONE;
                  end
               end
            end
            SHIFT: begin
               acc <= acc_nxt;
               cnt <= cnt - 1'b1;
               // Last step: flags come from the final accumulator value.
               if (cnt == SHW'(1)) begin
                  bus.Out      <= acc_nxt;
                  bus.Zero     <= (acc_nxt == '0);
                  bus.Carry    <= 1'b0;
                  bus.Negative <= acc_nxt[W-1];
                  bus.Illegal  <= 1'b0;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (W = 8)
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.W(8)) bus ();

   alu_seq #(.W(8)) dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] out;
      logic       z, c, n, il;
      int         lat;
      int         hold;
      bit         poke;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode rules.
   function automatic void model(input int a, input int b, input int op,
                                 output int res, output int z, output int c,
                                 output int n, output int il, output int lat);
      int amt;
      int s;
      res = 0; c = 0; il = 0; lat = 1;
      amt = (b > 8) ? 8 : b;
      case (op)
         0:  begin res = (a * (1 << amt)) % 256; lat = 1 + amt; end
         1:  begin res = a / (1 << amt);         lat = 1 + amt; end
         2:  res = a & b;
         3:  res = a | b;
         8:  res = (a >= b) ? 1 : 0;
         9:  res = (a == b) ? 1 : 0;
         10: res = (256 - a) % 256;
         11: begin s = a + b; res = s % 256; c = s / 256; end
         13: res = (a != b) ? 1 : 0;
         default: il = 1;
      endcase
      z = (res == 0) ? 1 : 0;
      n = (res >= 128) ? 1 : 0;
   endfunction

   // Applies one operation starting at a negedge; ends at a negedge after the
   // result handshake. poke drives a junk request during the first SHIFT
   // cycles, which must be ignored.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input int hold, input bit poke,
                         output logic [11:0] got, output int lat);
      bit busy_bad = 0;
      bit hold_bad = 0;
      bus.InputA   = a;
      bus.InputB   = b;
      bus.OP       = op;
      bus.in_valid = 1'b1;
      #1 check("in_ready_at_accept", int'(bus.in_ready), 1);
      @(negedge clk);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         if (bus.in_ready !== 1'b0) busy_bad = 1;
         if (poke && lat < 3) begin
            bus.InputA   = 8'h55;
            bus.InputB   = 8'h55;
            bus.OP       = 4'b1011;
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.in_valid = 1'b0;
      got = {bus.Out, bus.Zero, bus.Carry, bus.Negative, bus.Illegal};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if ({bus.Out, bus.Zero, bus.Carry, bus.Negative, bus.Illegal} !== got ||
             bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) hold_bad = 1;
      end
      check("busy_in_ready_low", int'(busy_bad), 0);
      if (hold > 0) check("hold_stable", int'(hold_bad), 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("release_out_valid", int'(bus.out_valid), 0);
      check("release_in_ready", int'(bus.in_ready), 1);
   endtask

   initial begin
      logic [11:0] got;
      int lat;
      int er, ez, ec, en, ei, elat;
      logic [7:0] ra, rb;
      logic [3:0] rop;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.InputA    = '0;
      bus.InputB    = '0;
      bus.OP        = '0;

      //        a      b      op       out    z  c  n  il lat hold poke
      vecs.push_back('{8'hFF, 8'h01, 4'b1011, 8'h00, 1, 1, 0, 0, 1, 0, 0});
      vecs.push_back('{8'h01, 8'h03, 4'b0000, 8'h08, 0, 0, 0, 0, 4, 0, 1});
      vecs.push_back('{8'h80, 8'h09, 4'b0001, 8'h00, 1, 0, 0, 0, 9, 0, 0});
      vecs.push_back('{8'h80, 8'h00, 4'b0001, 8'h80, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{8'h03, 8'h04, 4'b1000, 8'h00, 1, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{8'h02, 8'h02, 4'b1001, 8'h01, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{8'h01, 8'h03, 4'b1101, 8'h01, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{8'h01, 8'h00, 4'b1010, 8'hFF, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{8'h05, 8'h06, 4'b1011, 8'h0B, 0, 0, 0, 0, 1, 5, 0});
      vecs.push_back('{8'hC3, 8'h0F, 4'b0010, 8'h03, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{8'hC3, 8'h0F, 4'b0011, 8'hCF, 0, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{8'hA5, 8'h08, 4'b0000, 8'h00, 1, 0, 0, 0, 9, 0, 0});
      vecs.push_back('{8'h12, 8'h34, 4'b1111, 8'h00, 1, 0, 0, 1, 1, 0, 0});

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset_in_ready", int'(bus.in_ready), 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_outputs",
            int'({bus.Out, bus.Zero, bus.Carry, bus.Negative, bus.Illegal}), 0);
      reset = 1'b0;
      #1 check("post_reset_in_ready", int'(bus.in_ready), 1);

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, vecs[i].poke, got, lat);
         check($sformatf("vec%0d_result", i), int'(got),
               int'({vecs[i].out, vecs[i].z, vecs[i].c, vecs[i].n, vecs[i].il}));
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      end

      // Reset on the 3rd SHIFT cycle of LSH 1 by 7
      bus.InputA   = 8'h01;
      bus.InputB   = 8'h07;
      bus.OP       = 4'b0000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 check("midreset_in_ready_during", int'(bus.in_ready), 0);
      @(negedge clk);
      check("midreset_out_valid", int'(bus.out_valid), 0);
      check("midreset_outputs",
            int'({bus.Out, bus.Zero, bus.Carry, bus.Negative, bus.Illegal}), 0);
      reset = 1'b0;
      @(negedge clk);
      check("midreset_no_result", int'(bus.out_valid), 0);
      check("midreset_in_ready_after", int'(bus.in_ready), 1);
      run_op(8'h00, 8'h00, 4'b0100, 0, 0, got, lat);
      check("illegal_result", int'(got), int'({8'h00, 1'b1, 1'b0, 1'b0, 1'b1}));
      check("illegal_latency", lat, 1);

      // Randomised ops against the reference model
      for (int k = 0; k < 150; k++) begin
         ra  = 8'($urandom);
         rop = 4'($urandom);
         rb  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
         model(int'(ra), int'(rb), int'(rop), er, ez, ec, en, ei, elat);
         run_op(ra, rb, rop, $urandom_range(0, 2), 0, got, lat);
         check($sformatf("rnd%0d_op%0h_result", k, rop), int'(got),
               (er << 4) | (ez << 3) | (ec << 2) | (en << 1) | ei);
         check($sformatf("rnd%0d_op%0h_latency", k, rop), lat, elat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle 8-bit ALU. It keeps that ALU's opcode set and encodings and generalises the data width. It adds registered results, Carry/Negative/Illegal flags, valid/ready flow control and multi-bit shifts executed iteratively, one bit per cycle. It sits between the register file/decode stage and writeback; the result is held until writeback accepts it.

Parameters:
W, 8, datapath width in bits (W >= 2).
SHW, $clog2(W)+1, width of the internal shift counter (localparam, derived).

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands and OP are presented.
in_ready  output  1  block can accept an operation (high only in IDLE and only while Reset is low).
InputA  input  W  operand A.
InputB  input  W  operand B; also the shift amount for LSH/RSH.
OP  input  4  opcode (op_mne from definitions package).
out_valid  output  1  Out and flags hold a completed result.
out_ready  input  1  consumer accepts the result.
Out  output  W  result.
Zero  output  1  Out == 0.
Carry  output  1  ADD carry-out; 0 for all other ops.
Negative  output  1  Out[W-1].
Illegal  output  1  OP is not a defined opcode.

Behaviour:
- Reset: state=IDLE; Out=0; Zero=0, Carry=0, Negative=0, Illegal=0; out_valid=0. in_ready is 0 while Reset is high and 1 on the first cycle after it falls.
- Reset mid-operation (SHIFT or DONE): the operation is discarded and no result is delivered.
- Accept: on an edge with in_valid && in_ready, InputA, InputB and OP are sampled. Inputs are ignored at all other edges.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> DONE on accept for non-shift ops, and for LSH/RSH with amount 0. Latency is 1: out_valid is high after the accept edge.
- IDLE -> SHIFT on accept for LSH/RSH with amount != 0:
  - acc = InputA; cnt = min(InputB, W).
  - Each SHIFT edge shifts acc one bit (zero fill) and decrements cnt.
  - At cnt == 1 the FSM goes to DONE.
  - Latency is 1 + cnt edges. Amounts >= W clamp to W, giving Out = 0.
- DONE: out_valid=1. Out and all flags are stable until the edge with out_ready high, after which the FSM returns to IDLE with out_valid=0.
- No overlap: in_ready=0 in SHIFT and DONE. Peak throughput is one op per 2 cycles.
- Ops (unsigned, modulo 2^W):
  - LSH 0000: A << amt.
  - RSH 0001: A >> amt (logical).
  - AND 0010: A & B.
  - OR 0011: A | B (bitwise).
  - GEQ 1000: {0..,A>=B} (unsigned).
  - EQ 1001: {0..,A==B}.
  - NEG 1010: ~A+1.
  - ADD 1011: A+B, Carry = bit W of the (W+1)-bit sum.
  - NEQ 1101: {0..,A!=B}.
- Any other OP: Out=0, Illegal=1, Zero=1, latency 1.
- Flags are registered together with Out in the same edge. Zero and Negative are derived from the final Out; for shifts they use the final acc, not intermediate values.
- in_valid while busy: no effect. The source must hold the request until in_ready is high.

Decomposition:
- definitions package: the op_mne enum (existing encodings unchanged) and a new alu_state_t enum {IDLE, SHIFT, DONE}.
- Sub-module alu_comb (parameter W): purely combinational non-shift ops plus the Carry and Illegal decode.
- alu_seq contains the FSM, the shift accumulator/counter and the output registers.

Test Plan:
1. W=8, ADD A=8'hFF B=8'h01 -> one cycle after accept: Out=8'h00, Zero=1, Carry=1, Negative=0, out_valid=1.
2. LSH A=8'h01 B=3 -> out_valid rises 4 edges after accept with Out=8'h08; in_ready=0 throughout; a second in_valid during SHIFT is ignored.
3. RSH A=8'h80 B=9 (clamped to 8) -> Out=8'h00, Zero=1 after 9 edges. RSH A=8'h80 B=0 -> Out=8'h80, Negative=1 after 1 edge.
4. GEQ A=3 B=4 -> Out=8'h00, Zero=1. EQ A=2 B=2 -> Out=8'h01. NEQ A=1 B=3 -> Out=8'h01. NEG A=1 -> Out=8'hFF, Negative=1.
5. Backpressure: ADD A=5 B=6 with out_ready low for 5 cycles -> Out=8'h0B and out_valid=1 held stable, in_ready=0. On out_ready=1, the next edge gives out_valid=0, in_ready=1.
6. Reset asserted on the 3rd SHIFT cycle of LSH A=1 B=7 -> after that edge: out_valid=0, Out=8'h00, all flags 0; in_ready=1 the cycle after Reset drops. Then OP=4'b0100 -> Out=8'h00, Illegal=1, latency 1.
